vec_cache_xy_switch_bp: RTL and testbench

- Parametrised next-generation mesh switch tile for the vector-cache SRAM-group array.
- Carries per-channel data flits between W/E/S/N neighbours with valid/ready backpressure.
- Each output has per-channel buffering. Diagonal tiles use round-robin merging instead of fixed priority, and route by direction field.
- One instance per block/row crossing. Diagonal tiles (BLOCK_ID==ROW_ID) are the turn points between the row (E/W) and column (N/S) networks.

---
 rtl/vec_cache_xy_switch_bp.sv | 195 +++++++++++++++++++
 tb/tb_vec_cache_xy_switch_bp.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_cache_xy_switch_bp.sv
// Mesh switch tile: per-channel output FIFOs with valid/ready backpressure.
// Diagonal tiles merge W/N/S into E by round robin and steer E by the direction field.
module vec_cache_xy_switch_bp_fifo #(
    parameter int PW    = 64,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [PW-1:0] din_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          vld_o,
    output logic [PW-1:0] dout_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][PW-1:0] mem_q;
    logic [AW-1:0]            rd_q, wr_q;
    logic [CW-1:0]            cnt_q;
    logic                     push_ok, pop_ok;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign vld_o   = (cnt_q != '0);
    assign dout_o  = vld_o ? mem_q[rd_q] : '0;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && vld_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= nxt(wr_q);
            end
            if (pop_ok) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

module vec_cache_xy_switch_bp #(
    parameter int BLOCK_ID  = 0,
    parameter int ROW_ID    = 0,
    parameter int CH_NUM    = 8,
    parameter int PW        = 64,
    parameter int DIR_LSB   = 0,
    parameter int OUT_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH_NUM-1:0]    w_in_vld,
    input  logic [CH_NUM-1:0]    e_in_vld,
    input  logic [CH_NUM-1:0]    s_in_vld,
    input  logic [CH_NUM-1:0]    n_in_vld,
    output logic [CH_NUM-1:0]    w_in_rdy,
    output logic [CH_NUM-1:0]    e_in_rdy,
    output logic [CH_NUM-1:0]    s_in_rdy,
    output logic [CH_NUM-1:0]    n_in_rdy,
    input  logic [CH_NUM*PW-1:0] w_in_pld,
    input  logic [CH_NUM*PW-1:0] e_in_pld,
    input  logic [CH_NUM*PW-1:0] s_in_pld,
    input  logic [CH_NUM*PW-1:0] n_in_pld,
    output logic [CH_NUM-1:0]    w_out_vld,
    output logic [CH_NUM-1:0]    e_out_vld,
    output logic [CH_NUM-1:0]    s_out_vld,
    output logic [CH_NUM-1:0]    n_out_vld,
    input  logic [CH_NUM-1:0]    w_out_rdy,
    input  logic [CH_NUM-1:0]    e_out_rdy,
    input  logic [CH_NUM-1:0]    s_out_rdy,
    input  logic [CH_NUM-1:0]    n_out_rdy,
    output logic [CH_NUM*PW-1:0] w_out_pld,
    output logic [CH_NUM*PW-1:0] e_out_pld,
    output logic [CH_NUM*PW-1:0] s_out_pld,
    output logic [CH_NUM*PW-1:0] n_out_pld,
    output logic [CH_NUM-1:0]    err_dir,
    input  logic                 err_clr
);
    localparam bit DIAG = (BLOCK_ID == ROW_ID);

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        // FIFO index: 0=W out, 1=E out, 2=S out, 3=N out
        logic [3:0]          push, full, vld, pop;
        logic [3:0][PW-1:0]  din, dout;
        logic [PW-1:0]       w_pld, e_pld, s_pld, n_pld;

        assign w_pld = w_in_pld[c*PW +: PW];
        assign e_pld = e_in_pld[c*PW +: PW];
        assign s_pld = s_in_pld[c*PW +: PW];
        assign n_pld = n_in_pld[c*PW +: PW];
        assign pop   = {n_out_rdy[c], s_out_rdy[c], e_out_rdy[c], w_out_rdy[c]};

        vec_cache_xy_switch_bp_fifo #(.PW(PW), .DEPTH(OUT_DEPTH)) u_fifo [3:0] (
            .clk    (clk),
            .rst_n  (rst_n),
            .push_i (push),
            .din_i  (din),
            .pop_i  (pop),
            .full_o (full),
            .vld_o  (vld),
            .dout_o (dout)
        );

        assign w_out_vld[c]         = vld[0];
        assign e_out_vld[c]         = vld[1];
        assign s_out_vld[c]         = vld[2];
        assign n_out_vld[c]         = vld[3];
        assign w_out_pld[c*PW +: PW] = dout[0];
        assign e_out_pld[c*PW +: PW] = dout[1];
        assign s_out_pld[c*PW +: PW] = dout[2];
        assign n_out_pld[c*PW +: PW] = dout[3];

        if (DIAG) begin : g_diag
            logic [1:0] ptr_q;  // highest-priority requester: 0=N, 1=S, 2=W
            logic       g_n, g_s, g_w, t_n, t_s, t_w, err_q;
            logic [1:0] dir;

            // A grant never looks at its own valid, keeping in_rdy free of in_vld.
            always_comb begin
                g_n = 1'b0;
                g_s = 1'b0;
                g_w = 1'b0;
                case (ptr_q)
                    2'd1: begin
                        g_s = 1'b1;
                        g_w = !s_in_vld[c];
                        g_n = !s_in_vld[c] && !w_in_vld[c];
                    end
                    2'd2: begin
                        g_w = 1'b1;
                        g_n = !w_in_vld[c];
                        g_s = !w_in_vld[c] && !n_in_vld[c];
                    end
                    default: begin
                        g_n = 1'b1;
                        g_s = !n_in_vld[c];
                        g_w = !n_in_vld[c] && !s_in_vld[c];
                    end
                endcase
            end

            assign n_in_rdy[c] = g_n && !full[1];
            assign s_in_rdy[c] = g_s && !full[1];
            assign w_in_rdy[c] = g_w && !full[1];
            assign t_n = n_in_vld[c] && n_in_rdy[c];
            assign t_s = s_in_vld[c] && s_in_rdy[c];
            assign t_w = w_in_vld[c] && w_in_rdy[c];

            assign dir = e_pld[DIR_LSB +: 2];
            assign e_in_rdy[c] = (dir == 2'b00) ? !full[0] :
                                 (dir == 2'b10) ? !full[2] :
                                 (dir == 2'b11) ? !full[3] : 1'b1;

            assign push = {e_in_vld[c] && (dir == 2'b11) && !full[3],
                           e_in_vld[c] && (dir == 2'b10) && !full[2],
                           t_n || t_s || t_w,
                           e_in_vld[c] && (dir == 2'b00) && !full[0]};
            assign din  = {e_pld, e_pld, t_n ? n_pld : (t_s ? s_pld : w_pld), e_pld};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr_q <= 2'd0;
                    err_q <= 1'b0;
                end else begin
                    if (t_n)      ptr_q <= 2'd1;
                    else if (t_s) ptr_q <= 2'd2;
                    else if (t_w) ptr_q <= 2'd0;
                    // A fresh illegal flit outranks a simultaneous clear.
                    err_q <= (e_in_vld[c] && (dir == 2'b01)) || (err_q && !err_clr);
                end
            end

            assign err_dir[c] = err_q;
        end else begin : g_pass
            assign push = {s_in_vld[c] && !full[3], n_in_vld[c] && !full[2],
                           w_in_vld[c] && !full[1], e_in_vld[c] && !full[0]};
            assign din  = {s_pld, n_pld, w_pld, e_pld};
            assign w_in_rdy[c] = !full[1];
            assign e_in_rdy[c] = !full[0];
            assign n_in_rdy[c] = !full[2];
            assign s_in_rdy[c] = !full[3];
            assign err_dir[c]  = 1'b0;
        end
    end
endmodule

// File: tb/tb_vec_cache_xy_switch_bp.sv
// Directed bench: one straight-through tile and one diagonal tile on a shared clock/reset.
module tb_vec_cache_xy_switch_bp;
    localparam int CH = 8;
    localparam int PW = 64;
    localparam int DL = 62;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    logic [CH-1:0]    a_w_in_vld, a_e_in_vld, a_s_in_vld, a_n_in_vld;
    logic [CH-1:0]    a_w_in_rdy, a_e_in_rdy, a_s_in_rdy, a_n_in_rdy;
    logic [CH*PW-1:0] a_w_in_pld, a_e_in_pld, a_s_in_pld, a_n_in_pld;
    logic [CH-1:0]    a_w_out_vld, a_e_out_vld, a_s_out_vld, a_n_out_vld;
    logic [CH-1:0]    a_w_out_rdy, a_e_out_rdy, a_s_out_rdy, a_n_out_rdy;
    logic [CH*PW-1:0] a_w_out_pld, a_e_out_pld, a_s_out_pld, a_n_out_pld;
    logic [CH-1:0]    a_err_dir;

    logic [CH-1:0]    d_w_in_vld, d_e_in_vld, d_s_in_vld, d_n_in_vld;
    logic [CH-1:0]    d_w_in_rdy, d_e_in_rdy, d_s_in_rdy, d_n_in_rdy;
    logic [CH*PW-1:0] d_w_in_pld, d_e_in_pld, d_s_in_pld, d_n_in_pld;
    logic [CH-1:0]    d_w_out_vld, d_e_out_vld, d_s_out_vld, d_n_out_vld;
    logic [CH-1:0]    d_w_out_rdy, d_e_out_rdy, d_s_out_rdy, d_n_out_rdy;
    logic [CH*PW-1:0] d_w_out_pld, d_e_out_pld, d_s_out_pld, d_n_out_pld;
    logic [CH-1:0]    d_err_dir;

    vec_cache_xy_switch_bp #(.BLOCK_ID(1), .ROW_ID(0), .CH_NUM(CH), .PW(PW), .DIR_LSB(DL), .OUT_DEPTH(2)) u_pass (
        .clk(clk), .rst_n(rst_n),
        .w_in_vld(a_w_in_vld), .e_in_vld(a_e_in_vld), .s_in_vld(a_s_in_vld), .n_in_vld(a_n_in_vld),
        .w_in_rdy(a_w_in_rdy), .e_in_rdy(a_e_in_rdy), .s_in_rdy(a_s_in_rdy), .n_in_rdy(a_n_in_rdy),
        .w_in_pld(a_w_in_pld), .e_in_pld(a_e_in_pld), .s_in_pld(a_s_in_pld), .n_in_pld(a_n_in_pld),
        .w_out_vld(a_w_out_vld), .e_out_vld(a_e_out_vld), .s_out_vld(a_s_out_vld), .n_out_vld(a_n_out_vld),
        .w_out_rdy(a_w_out_rdy), .e_out_rdy(a_e_out_rdy), .s_out_rdy(a_s_out_rdy), .n_out_rdy(a_n_out_rdy),
        .w_out_pld(a_w_out_pld), .e_out_pld(a_e_out_pld), .s_out_pld(a_s_out_pld), .n_out_pld(a_n_out_pld),
        .err_dir(a_err_dir), .err_clr(err_clr)
    );

    vec_cache_xy_switch_bp #(.BLOCK_ID(2), .ROW_ID(2), .CH_NUM(CH), .PW(PW), .DIR_LSB(DL), .OUT_DEPTH(2)) u_diag (
        .clk(clk), .rst_n(rst_n),
        .w_in_vld(d_w_in_vld), .e_in_vld(d_e_in_vld), .s_in_vld(d_s_in_vld), .n_in_vld(d_n_in_vld),
        .w_in_rdy(d_w_in_rdy), .e_in_rdy(d_e_in_rdy), .s_in_rdy(d_s_in_rdy), .n_in_rdy(d_n_in_rdy),
        .w_in_pld(d_w_in_pld), .e_in_pld(d_e_in_pld), .s_in_pld(d_s_in_pld), .n_in_pld(d_n_in_pld),
        .w_out_vld(d_w_out_vld), .e_out_vld(d_e_out_vld), .s_out_vld(d_s_out_vld), .n_out_vld(d_n_out_vld),
        .w_out_rdy(d_w_out_rdy), .e_out_rdy(d_e_out_rdy), .s_out_rdy(d_s_out_rdy), .n_out_rdy(d_n_out_rdy),
        .w_out_pld(d_w_out_pld), .e_out_pld(d_e_out_pld), .s_out_pld(d_s_out_pld), .n_out_pld(d_n_out_pld),
        .err_dir(d_err_dir), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_w_in_vld = '0; a_e_in_vld = '0; a_s_in_vld = '0; a_n_in_vld = '0;
        d_w_in_vld = '0; d_e_in_vld = '0; d_s_in_vld = '0; d_n_in_vld = '0;
        a_w_out_rdy = '1; a_e_out_rdy = '1; a_s_out_rdy = '1; a_n_out_rdy = '1;
        d_w_out_rdy = '1; d_e_out_rdy = '1; d_s_out_rdy = '1; d_n_out_rdy = '1;
        err_clr = 1'b0;
    endtask

    // Held-output monitor: a stalled output must keep valid high and payload steady.
    logic        fa0 = 1'b0, fa1 = 1'b0, fd5 = 1'b0;
    logic [63:0] pa0, pa1, pd5;
    always @(negedge clk) begin
        if (!rst_n) begin
            fa0 <= 1'b0; fa1 <= 1'b0; fd5 <= 1'b0;
        end else begin
            if (fa0) begin chk("hold_a0_vld", a_e_out_vld[0], 1); chk("hold_a0_pld", a_e_out_pld[0*PW +: PW], pa0); end
            if (fa1) begin chk("hold_a1_vld", a_e_out_vld[1], 1); chk("hold_a1_pld", a_e_out_pld[1*PW +: PW], pa1); end
            if (fd5) begin chk("hold_d5_vld", d_e_out_vld[5], 1); chk("hold_d5_pld", d_e_out_pld[5*PW +: PW], pd5); end
            fa0 <= a_e_out_vld[0] && !a_e_out_rdy[0]; pa0 <= a_e_out_pld[0*PW +: PW];
            fa1 <= a_e_out_vld[1] && !a_e_out_rdy[1]; pa1 <= a_e_out_pld[1*PW +: PW];
            fd5 <= d_e_out_vld[5] && !d_e_out_rdy[5]; pd5 <= d_e_out_pld[5*PW +: PW];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] base [3] = '{64'h1000, 64'h2000, 64'h3000};
    logic [1:0]  dirs [3] = '{2'b00, 2'b10, 2'b11};
    logic [63:0] pays [3] = '{64'h10, 64'h20, 64'h30};

    initial begin
        int snt, rcv, nc, sc, wc, oc;
        logic [63:0] exp_p;
        idle();
        a_w_in_pld = '0; a_e_in_pld = '0; a_s_in_pld = '0; a_n_in_pld = '0;
        d_w_in_pld = '0; d_e_in_pld = '0; d_s_in_pld = '0; d_n_in_pld = '0;
        step(); step();
        chk("rst_a_vld", {a_w_out_vld, a_e_out_vld, a_s_out_vld, a_n_out_vld}, 0);
        chk("rst_d_vld", {d_w_out_vld, d_e_out_vld, d_s_out_vld, d_n_out_vld}, 0);
        chk("rst_pld", |{a_w_out_pld, a_e_out_pld, a_s_out_pld, a_n_out_pld,
                         d_w_out_pld, d_e_out_pld, d_s_out_pld, d_n_out_pld}, 0);
        chk("rst_err", {a_err_dir, d_err_dir}, 0);
        chk("rst_a_rdy", {a_w_in_rdy, a_e_in_rdy, a_s_in_rdy, a_n_in_rdy}, 32'hFFFF_FFFF);
        chk("rst_d_rdy", {d_w_in_rdy, d_e_in_rdy, d_s_in_rdy, d_n_in_rdy}, 32'hFFFF_FFFF);
        rst_n = 1'b1;
        step();

        // Backpressure on a straight W->E path, depth 2
        snt = 0; rcv = 0;
        for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
            a_w_in_vld[0] = (snt < 10);
            a_w_in_pld[0*PW +: PW] = 64'h100 + 64'(snt);
            a_e_out_rdy[0] = (cyc >= 4);
            #1;
            if (cyc < 2) chk("t2_rdy_open", a_w_in_rdy[0], 1);
            if (cyc >= 2 && cyc <= 4) chk("t2_rdy_full", a_w_in_rdy[0], 0);
            if (a_e_out_vld[0] && a_e_out_rdy[0]) begin
                chk("t2_order", a_e_out_pld[0*PW +: PW], 64'h100 + 64'(rcv));
                rcv++;
            end
            if (a_w_in_vld[0] && a_w_in_rdy[0]) snt++;
            step();
        end
        chk("t2_count", rcv, 10);
        idle(); step();
        chk("t2_drained", a_e_out_vld[0], 0);

        // Round robin N,S,W into E on channel 5
        nc = 0; sc = 0; wc = 0; oc = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            d_n_in_vld[5] = (cyc < 12); d_n_in_pld[5*PW +: PW] = 64'h1000 + 64'(nc);
            d_s_in_vld[5] = (cyc < 12); d_s_in_pld[5*PW +: PW] = 64'h2000 + 64'(sc);
            d_w_in_vld[5] = (cyc < 12); d_w_in_pld[5*PW +: PW] = 64'h3000 + 64'(wc);
            #1;
            if (cyc == 0) begin
                chk("t3_rdy_n", d_n_in_rdy[5], 1);
                chk("t3_rdy_s", d_s_in_rdy[5], 0);
                chk("t3_rdy_w", d_w_in_rdy[5], 0);
            end
            if (d_e_out_vld[5]) begin
                if (oc < 12) chk("t3_order", d_e_out_pld[5*PW +: PW], base[oc % 3] + 64'(oc / 3));
                oc++;
            end
            if (d_n_in_vld[5] && d_n_in_rdy[5]) nc++;
            if (d_s_in_vld[5] && d_s_in_rdy[5]) sc++;
            if (d_w_in_vld[5] && d_w_in_rdy[5]) wc++;
            step();
        end
        chk("t3_share_n", nc, 4);
        chk("t3_share_s", sc, 4);
        chk("t3_share_w", wc, 4);
        chk("t3_out_cnt", oc, 12);
        idle(); step();

        // E-input routing on channel 2
        for (int k = 0; k < 3; k++) begin
            exp_p = {dirs[k], pays[k][61:0]};
            d_e_in_vld[2] = 1'b1;
            d_e_in_pld[2*PW +: PW] = exp_p;
            #1;
            chk("t4_rdy", d_e_in_rdy[2], 1);
            step();
            d_e_in_vld[2] = 1'b0;
            #1;
            chk("t4_w_vld", d_w_out_vld[2], (k == 0));
            chk("t4_s_vld", d_s_out_vld[2], (k == 1));
            chk("t4_n_vld", d_n_out_vld[2], (k == 2));
            chk("t4_e_vld", d_e_out_vld[2], 0);
            if (k == 0) chk("t4_w_pld", d_w_out_pld[2*PW +: PW], exp_p);
            if (k == 1) chk("t4_s_pld", d_s_out_pld[2*PW +: PW], exp_p);
            if (k == 2) chk("t4_n_pld", d_n_out_pld[2*PW +: PW], exp_p);
        end
        step();

        // Illegal east direction on channel 7
        d_e_in_vld[7] = 1'b1;
        d_e_in_pld[7*PW +: PW] = {2'b01, 62'h77};
        #1;
        chk("t5_rdy", d_e_in_rdy[7], 1);
        chk("t5_err_pre", d_err_dir, 0);
        step();
        d_e_in_vld[7] = 1'b0;
        #1;
        chk("t5_err_set", d_err_dir, 8'h80);
        chk("t5_no_out", {d_w_out_vld[7], d_e_out_vld[7], d_s_out_vld[7], d_n_out_vld[7]}, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        #1;
        chk("t5_err_clr", d_err_dir, 0);
        err_clr = 1'b1;
        d_e_in_vld[7] = 1'b1;
        step();
        err_clr = 1'b0;
        d_e_in_vld[7] = 1'b0;
        #1;
        chk("t5_set_wins", d_err_dir, 8'h80);

        // Asynchronous reset with data buffered, then first flit latency
        a_e_out_rdy = '0;
        a_w_in_vld[3] = 1'b1;
        a_w_in_pld[3*PW +: PW] = 64'h11;
        step();
        a_w_in_pld[3*PW +: PW] = 64'h12;
        step();
        a_w_in_vld[3] = 1'b0;
        #1;
        chk("t1_pre_vld", a_e_out_vld[3], 1);
        chk("t1_pre_rdy", a_w_in_rdy[3], 0);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_vld", {a_w_out_vld, a_e_out_vld, a_s_out_vld, a_n_out_vld}, 0);
        chk("t1_rst_pld", |{a_w_out_pld, a_e_out_pld, a_s_out_pld, a_n_out_pld}, 0);
        chk("t1_rst_err", d_err_dir, 0);
        step();
        rst_n = 1'b1;
        a_e_out_rdy = '1;
        a_w_in_vld[3] = 1'b1;
        a_w_in_pld[3*PW +: PW] = 64'hA5;
        #1;
        chk("t1_post_rdy", a_w_in_rdy[3], 1);
        chk("t1_post_empty", a_e_out_vld[3], 0);
        step();
        a_w_in_vld[3] = 1'b0;
        #1;
        chk("t1_lat_vld", a_e_out_vld[3], 1);
        chk("t1_lat_pld", a_e_out_pld[3*PW +: PW], 64'hA5);
        step();
        chk("t1_single", a_e_out_vld[3], 0);

        // Channel isolation: ch1 stalled, ch4 streaming
        a_e_out_rdy[1] = 1'b0;
        a_w_in_vld[1] = 1'b1;
        a_w_in_pld[1*PW +: PW] = 64'h111;
        for (int cyc = 0; cyc < 9; cyc++) begin
            a_w_in_vld[4] = (cyc < 8);
            a_w_in_pld[4*PW +: PW] = 64'h400 + 64'(cyc);
            #1;
            if (cyc < 8) chk("t6_rdy4", a_w_in_rdy[4], 1);
            if (cyc >= 2) chk("t6_rdy1_blk", a_w_in_rdy[1], 0);
            if (cyc >= 1) begin
                chk("t6_vld4", a_e_out_vld[4], 1);
                chk("t6_pld4", a_e_out_pld[4*PW +: PW], 64'h400 + 64'(cyc - 1));
            end
            step();
        end
        idle(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
